// File: rtl/axil_slave_regfile_pkg.sv
// Shared AXI-Lite response codes and FSM state types for the register-file slave.
package axil_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axil_slave_regfile_if.sv
// AXI-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
interface axil_slave_regfile_if
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;
  resp_t                   b_resp;
  logic                    b_valid;
  logic                    b_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  resp_t                   r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_addr, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport slave (
    input aw_addr, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );

endinterface

// File: rtl/axil_slave_regfile_reg_bank.sv
// Byte-strobed 32-bit register array with one combinational read port.
// AXIL_REGFILE_WRCNT_EN adds a read-only count of accepted writes at index NUM_REGS.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int IDX_WIDTH = 2,
  parameter int NUM_REGS  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   i_wr_en,
  input  logic [IDX_WIDTH-1:0]   i_wr_idx,
  input  logic [31:0]            i_wr_data,
  input  logic [3:0]             i_wr_strb,
  output logic                   o_wr_ok,
  input  logic [IDX_WIDTH-1:0]   i_rd_idx,
  output logic [31:0]            o_rd_data,
  output logic                   o_rd_ok,
  output logic [NUM_REGS*32-1:0] o_regs
);

  logic [31:0] r_regs [NUM_REGS];
  logic [31:0] w_wr_idx;
  logic [31:0] w_rd_idx;

  if (NUM_REGS < 1 || NUM_REGS > 2**IDX_WIDTH) begin : g_bad_num_regs
    $error("axil_reg_bank: NUM_REGS out of range for address width");
  end

  assign w_wr_idx = 32'(i_wr_idx);
  assign w_rd_idx = 32'(i_rd_idx);
  assign o_wr_ok  = (w_wr_idx < NUM_REGS);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_wr_en && o_wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_idx == i) begin
          for (int b = 0; b < 4; b++) begin
            if (i_wr_strb[b]) r_regs[i][8*b +: 8] <= i_wr_data[8*b +: 8];
          end
        end
      end
    end
  end

`ifdef AXIL_REGFILE_WRCNT_EN
  logic [31:0] r_wr_cnt;

  if (NUM_REGS + 1 > 2**IDX_WIDTH) begin : g_no_room_for_cnt
    $error("axil_reg_bank: no address slot left for the write counter");
  end

  // Only writes that land in a real register count; the counter slot itself rejects writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_wr_cnt <= '0;
    else if (i_wr_en && o_wr_ok) r_wr_cnt <= r_wr_cnt + 32'd1;
  end
`endif

  always_comb begin
    o_rd_data = '0;
    o_rd_ok   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rd_idx == i) begin
        o_rd_data = r_regs[i];
        o_rd_ok   = 1'b1;
      end
    end
`ifdef AXIL_REGFILE_WRCNT_EN
    if (w_rd_idx == NUM_REGS) begin
      o_rd_data = r_wr_cnt;
      o_rd_ok   = 1'b1;
    end
`endif
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_regs[g*32 +: 32] = r_regs[g];
  end

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI-Lite slave register file with independent write (AW/W/B) and read (AR/R) FSMs.
// Optional macro AXIL_REGFILE_WRCNT_EN adds a write counter at index NUM_REGS.
module axil_slave_regfile
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  axil_slave_regfile_if.slave            s_axil,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axil_slave_regfile: DATA_WIDTH must be 32");
  end

  wr_state_t r_wstate;
  rd_state_t r_rstate;

  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [3:0]            r_w_strb;
  resp_t                 r_b_resp;
  logic [DATA_WIDTH-1:0] r_r_data;
  resp_t                 r_r_resp;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_do_write;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [3:0]            w_wr_strb;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_unused_addr_bits;

  assign s_axil.aw_ready = !rst_i && (r_wstate == W_IDLE || r_wstate == W_HAVE_W);
  assign s_axil.w_ready  = !rst_i && (r_wstate == W_IDLE || r_wstate == W_HAVE_AW);
  assign s_axil.b_valid  = (r_wstate == W_RESP);
  assign s_axil.b_resp   = r_b_resp;
  assign s_axil.ar_ready = !rst_i && (r_rstate == R_IDLE);
  assign s_axil.r_valid  = (r_rstate == R_DATA);
  assign s_axil.r_data   = r_r_data;
  assign s_axil.r_resp   = r_r_resp;

  assign w_aw_hs = s_axil.aw_valid && s_axil.aw_ready;
  assign w_w_hs  = s_axil.w_valid && s_axil.w_ready;
  assign w_ar_hs = s_axil.ar_valid && s_axil.ar_ready;

  // A write commits on whichever edge completes the second of the AW/W handshakes.
  always_comb begin
    w_do_write = 1'b0;
    case (r_wstate)
      W_IDLE:    w_do_write = w_aw_hs && w_w_hs;
      W_HAVE_AW: w_do_write = w_w_hs;
      W_HAVE_W:  w_do_write = w_aw_hs;
      default:   w_do_write = 1'b0;
    endcase
  end

  assign w_wr_addr = (r_wstate == W_HAVE_AW) ? r_aw_addr : s_axil.aw_addr;
  assign w_wr_data = (r_wstate == W_HAVE_W) ? r_w_data : s_axil.w_data;
  assign w_wr_strb = (r_wstate == W_HAVE_W) ? r_w_strb : s_axil.w_strb;

  assign w_unused_addr_bits = ^{w_wr_addr[1:0], s_axil.ar_addr[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wstate  <= W_IDLE;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_b_resp  <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs && w_w_hs) begin
            r_wstate <= W_RESP;
          end else if (w_aw_hs) begin
            r_aw_addr <= s_axil.aw_addr;
            r_wstate  <= W_HAVE_AW;
          end else if (w_w_hs) begin
            r_w_data <= s_axil.w_data;
            r_w_strb <= s_axil.w_strb;
            r_wstate <= W_HAVE_W;
          end
        end
        W_HAVE_AW: if (w_w_hs) r_wstate <= W_RESP;
        W_HAVE_W:  if (w_aw_hs) r_wstate <= W_RESP;
        W_RESP:    if (s_axil.b_ready) r_wstate <= W_IDLE;
        default:   r_wstate <= W_IDLE;
      endcase
      if (w_do_write) r_b_resp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read data is captured from the pre-edge register contents, so a colliding write is not visible.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rstate <= R_IDLE;
      r_r_data <= '0;
      r_r_resp <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_r_data <= w_rd_ok ? w_rd_data : '0;
            r_r_resp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            r_rstate <= R_DATA;
          end
        end
        R_DATA:  if (s_axil.r_ready) r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  axil_reg_bank #(
    .IDX_WIDTH (IDX_W),
    .NUM_REGS  (NUM_REGS)
  ) u_bank (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_wr_en   (w_do_write),
    .i_wr_idx  (w_wr_addr[ADDR_WIDTH-1:2]),
    .i_wr_data (w_wr_data),
    .i_wr_strb (w_wr_strb),
    .o_wr_ok   (w_wr_ok),
    .i_rd_idx  (s_axil.ar_addr[ADDR_WIDTH-1:2]),
    .o_rd_data (w_rd_data),
    .o_rd_ok   (w_rd_ok),
    .o_regs    (regs_o)
  );

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Randomized self-checking bench for axil_slave_regfile against a word/byte-level register model.
// Follows AXIL_REGFILE_WRCNT_EN in the model when the macro is defined.
module tb_axil_slave_regfile;
  import axil_pkg::*;

  localparam int AW    = 5;
  localparam int NREGS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREGS*32-1:0] regsOut;

  int numChecks = 0;
  int numErrors = 0;

  logic [31:0] modelRegs [NREGS];
  logic [31:0] modelCnt;

  axil_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  axil_slave_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (32),
    .NUM_REGS   (NREGS)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .s_axil (bus),
    .regs_o (regsOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: plain word array plus a count of accepted writes.
  task automatic modelReset();
    for (int i = 0; i < NREGS; i++) modelRegs[i] = '0;
    modelCnt = '0;
  endtask

  function automatic logic [1:0] modelWrite(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr[AW-1:2]);
    if (idx >= NREGS) return RESP_SLVERR;
    for (int b = 0; b < 4; b++)
      if (strb[b]) modelRegs[idx][8*b +: 8] = data[8*b +: 8];
    modelCnt = modelCnt + 1;
    return RESP_OKAY;
  endfunction

  task automatic modelRead(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int idx;
    idx  = int'(addr[AW-1:2]);
    data = '0;
    resp = RESP_SLVERR;
    if (idx < NREGS) begin
      data = modelRegs[idx];
      resp = RESP_OKAY;
    end
`ifdef AXIL_REGFILE_WRCNT_EN
    else if (idx == NREGS) begin
      data = modelCnt;
      resp = RESP_OKAY;
    end
`endif
  endtask

  function automatic logic [NREGS*32-1:0] modelFlat();
    logic [NREGS*32-1:0] f;
    for (int i = 0; i < NREGS; i++) f[i*32 +: 32] = modelRegs[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendAw(input logic [AW-1:0] addr, input int delay);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    repeat (delay) tick();
    bus.aw_addr  = addr;
    bus.aw_valid = 1'b1;
    while (!got && n < 64) begin
      @(negedge clk);
      got = bus.aw_ready;
      tick();
      n++;
    end
    bus.aw_valid = 1'b0;
    if (!got) checkOutput("awTimeout", got, 1'b1);
  endtask

  task automatic sendW(input logic [31:0] data, input logic [3:0] strb, input int delay);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    repeat (delay) tick();
    bus.w_data  = data;
    bus.w_strb  = strb;
    bus.w_valid = 1'b1;
    while (!got && n < 64) begin
      @(negedge clk);
      got = bus.w_ready;
      tick();
      n++;
    end
    bus.w_valid = 1'b0;
    if (!got) checkOutput("wTimeout", got, 1'b1);
  endtask

  task automatic sendAr(input logic [AW-1:0] addr, input int delay);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    repeat (delay) tick();
    bus.ar_addr  = addr;
    bus.ar_valid = 1'b1;
    while (!got && n < 64) begin
      @(negedge clk);
      got = bus.ar_ready;
      tick();
      n++;
    end
    bus.ar_valid = 1'b0;
    if (!got) checkOutput("arTimeout", got, 1'b1);
  endtask

  task automatic waitB(input int hold, output logic [1:0] resp, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.b_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    lat  = n;
    resp = bus.b_resp;
    if (!bus.b_valid) begin
      checkOutput("bTimeout", bus.b_valid, 1'b1);
      tick();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("bHold", bus.b_valid, 1'b1);
      checkOutput("bRespStable", bus.b_resp, resp);
      checkOutput("wrReadyInResp", {bus.aw_ready, bus.w_ready}, 2'b00);
    end
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
  endtask

  task automatic waitR(input int hold, output logic [31:0] data, output logic [1:0] resp, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.r_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    lat  = n;
    data = bus.r_data;
    resp = bus.r_resp;
    if (!bus.r_valid) begin
      checkOutput("rTimeout", bus.r_valid, 1'b1);
      tick();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("rHold", bus.r_valid, 1'b1);
      checkOutput("rDataStable", {bus.r_resp, bus.r_data}, {resp, data});
      checkOutput("arReadyInData", bus.ar_ready, 1'b0);
    end
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
  endtask

  task automatic doWrite(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int awDelay, input int wDelay, input int bHold, input string tag);
    logic [1:0] expResp;
    logic [1:0] resp;
    int lat;
    fork
      sendAw(addr, awDelay);
      sendW(data, strb, wDelay);
    join
    expResp = modelWrite(addr, data, strb);
    waitB(bHold, resp, lat);
    checkOutput({tag, "_bresp"}, resp, expResp);
    checkOutput({tag, "_blat"}, lat, 0);
    checkOutput({tag, "_regs"}, regsOut, modelFlat());
  endtask

  task automatic doRead(input logic [AW-1:0] addr, input int rHold, input string tag);
    logic [31:0] expData;
    logic [31:0] data;
    logic [1:0] expResp;
    logic [1:0] resp;
    int lat;
    sendAr(addr, 0);
    modelRead(addr, expData, expResp);
    waitR(rHold, data, resp, lat);
    checkOutput({tag, "_rdata"}, data, expData);
    checkOutput({tag, "_rresp"}, resp, expResp);
    checkOutput({tag, "_rlat"}, lat, 0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ready"}, {bus.aw_ready, bus.w_ready, bus.ar_ready}, 3'b111);
    checkOutput({tag, "_valid"}, {bus.b_valid, bus.r_valid}, 2'b00);
    checkOutput({tag, "_resp"}, {bus.b_resp, bus.r_resp}, 4'b0000);
    checkOutput({tag, "_rdata"}, bus.r_data, 32'h0);
    checkOutput({tag, "_regs"}, regsOut, modelFlat());
  endtask

  // Random mix of writes and reads over the whole address space, including unaligned and unmapped addresses.
  task automatic applyStimulus(input int numOps);
    for (int k = 0; k < numOps; k++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 2**AW - 1));
      if ($urandom_range(0, 1) == 1)
        doWrite(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), "rndWr");
      else
        doRead(a, $urandom_range(0, 2), "rndRd");
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] resp;
    logic [1:0] expResp;
    logic [31:0] data;
    logic [31:0] expData;
    int lat;

    bus.aw_addr = '0; bus.aw_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_valid = 1'b0;
    bus.b_ready = 1'b0;
    bus.ar_addr = '0; bus.ar_valid = 1'b0;
    bus.r_ready = 1'b0;
    modelReset();

    rst = 1'b1;
    repeat (3) tick();
    checkOutput("rstReadyLow", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    checkIdle("reset");
    tick();

    for (int i = 0; i < 4; i++)
      doWrite(AW'(i * 4), 32'h10101010 * (i + 1), 4'hF, 0, 0, 0, "seqWr");
    checkOutput("seqRegs", regsOut, 128'h40404040_30303030_20202020_10101010);
    doRead(5'h10, 0, "cntRd");

    doWrite(5'h04, 32'hDEADBEEF, 4'b0101, 2, 0, 0, "wFirst");
    checkOutput("wFirstReg1", regsOut[63:32], 32'h20AD20EF);

    // B backpressure with a competing AW that must not be accepted until after the response.
    fork
      sendAw(5'h0C, 0);
      sendW(32'h44444444, 4'hF, 0);
    join
    expResp = modelWrite(5'h0C, 32'h44444444, 4'hF);
    bus.aw_addr  = 5'h08;
    bus.aw_valid = 1'b1;
    waitB(5, resp, lat);
    bus.aw_valid = 1'b0;
    checkOutput("bpResp", resp, expResp);
    @(negedge clk);
    checkOutput("bpAwNotTaken", {bus.aw_ready, bus.w_ready}, 2'b11);
    tick();

    doRead(5'h08, 0, "rd8");
    doRead(5'h08, 3, "rd8Hold");
    doRead(5'h14, 0, "rdOor");
    doWrite(5'h14, 32'hFFFFFFFF, 4'hF, 0, 0, 0, "wrOor");
    doWrite(5'h10, 32'h12345678, 4'hF, 0, 1, 1, "wrCntSlot");

    fork
      sendAw(5'h00, 0);
      sendW(32'h55555555, 4'hF, 0);
      sendAr(5'h00, 0);
    join
    modelRead(5'h00, expData, expResp);
    expResp = modelWrite(5'h00, 32'h55555555, 4'hF);
    waitR(0, data, resp, lat);
    checkOutput("collideRdata", data, expData);
    checkOutput("collideRlat", lat, 0);
    waitB(0, resp, lat);
    checkOutput("collideBresp", resp, expResp);
    doRead(5'h00, 0, "afterCollide");

    applyStimulus(60);

    fork
      sendAw(5'h04, 0);
      sendW(32'hA5A5A5A5, 4'hF, 0);
    join
    @(negedge clk);
    checkOutput("preRstBvalid", bus.b_valid, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("midRstReadyLow", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 3'b000);
    tick();
    rst = 1'b0;
    modelReset();
    @(negedge clk);
    checkIdle("midRst");
    tick();

    doRead(5'h10, 0, "cntAfterRst");
    doWrite(5'h08, 32'h0BADF00D, 4'b1100, 1, 0, 0, "postRstWr");
    doRead(5'h10, 1, "cntAfterOne");

    $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
    $finish;
  end

endmodule
